neo_pixel_receiver: RTL and testbench

- Decoder for the single-wire NeoPixel bit stream produced by the strand controller, clocked by the same 50 MHz clock.
- Measures the high-pulse width of each bit to recover 0/1 and assembles 24-bit GRB pixel words, MSB first.
- Detects the 50 us low latch gap that ends a frame.
- Serves as the loopback checker for the strand controller and as the input stage of a daisy-chained pixel emulator.

---
 rtl/neo_pixel_receiver.sv | 184 ++++++++++++++++++
 tb/tb_neo_pixel_receiver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neo_pixel_receiver.sv
// NeoPixel single-wire decoder: pulse-width bit recovery,
// 24-bit GRB word assembly and latch-gap frame detection.
module neo_pixel_receiver #(
    parameter int NUM_PIXELS   = 5,
    parameter int MIN_HIGH     = 8,
    parameter int HIGH_THRESH  = 27,
    parameter int MAX_HIGH     = 50,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        neo_data,
    output logic        pixel_valid,
    output logic [2:0]  pixel_index,
    output logic [23:0] pixel_grb,
    output logic        frame_done,
    output logic [2:0]  frame_pixels,
    output logic        frame_overflow,
    output logic        bit_error
);

    localparam logic [11:0] MIN_H   = 12'(MIN_HIGH);
    localparam logic [11:0] THRESH  = 12'(HIGH_THRESH);
    localparam logic [11:0] MAX_H   = 12'(MAX_HIGH);
    localparam logic [11:0] LATCH_C = 12'(LATCH_CYCLES);
    localparam logic [2:0]  NUM_W   = 3'(NUM_PIXELS);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        ERR
    } state_t;

    state_t      state;
    logic        s1, s2, s3;
    logic [11:0] high_cnt;
    logic [11:0] low_cnt;
    logic [4:0]  bit_cnt;
    logic [2:0]  word_cnt;
    logic [23:0] shift_reg;
    logic        ovf_flag;

    logic        rise;
    logic        new_bit;
    logic [23:0] new_word;
    logic        frame_has_data;

    assign rise           = s2 & ~s3;
    assign new_bit        = (high_cnt >= THRESH);
    assign new_word       = {shift_reg[22:0], new_bit};
    assign frame_has_data = (word_cnt != 3'd0) || (bit_cnt != 5'd0);

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    // Bring the asynchronous line into the clock domain and keep one sample of history
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= neo_data;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Pulse-width decoder, word assembler and frame tracker
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            high_cnt       <= 12'd0;
            low_cnt        <= 12'd0;
            bit_cnt        <= 5'd0;
            word_cnt       <= 3'd0;
            shift_reg      <= 24'd0;
            ovf_flag       <= 1'b0;
            pixel_valid    <= 1'b0;
            pixel_index    <= 3'd0;
            pixel_grb      <= 24'd0;
            frame_done     <= 1'b0;
            frame_pixels   <= 3'd0;
            frame_overflow <= 1'b0;
            bit_error      <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_error   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= 12'd1;
                        low_cnt  <= 12'd0;
                    end
                end
                HIGH: begin
                    if (s2) begin
                        if (high_cnt >= MAX_H) begin
                            // Over-long pulse: abandon the whole frame
                            state     <= ERR;
                            bit_error <= 1'b1;
                            bit_cnt   <= 5'd0;
                            word_cnt  <= 3'd0;
                            shift_reg <= 24'd0;
                            ovf_flag  <= 1'b0;
                            low_cnt   <= 12'd0;
                        end else begin
                            high_cnt <= sat_inc(high_cnt);
                        end
                    end else begin
                        state   <= LOW;
                        low_cnt <= 12'd1;
                        if (high_cnt >= MIN_H) begin
                            shift_reg <= new_word;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= 5'd0;
                                if (word_cnt < NUM_W) begin
                                    pixel_valid <= 1'b1;
                                    pixel_grb   <= new_word;
                                    pixel_index <= word_cnt;
                                    word_cnt    <= word_cnt + 3'd1;
                                end else begin
                                    ovf_flag <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                end
                LOW: begin
                    if (low_cnt >= LATCH_C) begin
                        // Latch gap wins over a coincident rise
                        if (frame_has_data) begin
                            frame_done     <= 1'b1;
                            frame_pixels   <= word_cnt;
                            frame_overflow <= ovf_flag;
                        end
                        if (bit_cnt != 5'd0) begin
                            bit_error <= 1'b1;
                        end
                        word_cnt  <= 3'd0;
                        bit_cnt   <= 5'd0;
                        ovf_flag  <= 1'b0;
                        shift_reg <= 24'd0;
                        low_cnt   <= 12'd0;
                        if (rise) begin
                            state    <= HIGH;
                            high_cnt <= 12'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (rise) begin
                        state    <= HIGH;
                        high_cnt <= 12'd1;
                        low_cnt  <= 12'd0;
                    end else begin
                        low_cnt <= sat_inc(low_cnt);
                    end
                end
                ERR: begin
                    if (low_cnt >= LATCH_C) begin
                        low_cnt <= 12'd0;
                        if (rise) begin
                            state    <= HIGH;
                            high_cnt <= 12'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (s2) begin
                        low_cnt <= 12'd0;
                    end else begin
                        low_cnt <= sat_inc(low_cnt);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neo_pixel_receiver.sv
// Directed testbench for neo_pixel_receiver.
// Drives pulse trains and checks decoded pixels and frame events.
module tb_neo_pixel_receiver;

    logic        clock;
    logic        reset;
    logic        neo_data;
    logic        pixel_valid;
    logic [2:0]  pixel_index;
    logic [23:0] pixel_grb;
    logic        frame_done;
    logic [2:0]  frame_pixels;
    logic        frame_overflow;
    logic        bit_error;

    int checks = 0;
    int errors = 0;

    int pv_cnt = 0;
    int fd_cnt = 0;
    int be_cnt = 0;
    logic [23:0] pv_grb [0:63];
    logic [2:0]  pv_idx [0:63];
    logic [2:0]  fd_pixels = 3'd0;
    logic        fd_ovf = 1'b0;
    logic        fd_be = 1'b0;

    int pv0, fd0, be0;
    logic [23:0] w;

    neo_pixel_receiver dut (
        .clock          (clock),
        .reset          (reset),
        .neo_data       (neo_data),
        .pixel_valid    (pixel_valid),
        .pixel_index    (pixel_index),
        .pixel_grb      (pixel_grb),
        .frame_done     (frame_done),
        .frame_pixels   (frame_pixels),
        .frame_overflow (frame_overflow),
        .bit_error      (bit_error)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Record output events away from the active edge
    always @(negedge clock) begin
        if (pixel_valid) begin
            pv_grb[pv_cnt[5:0]] <= pixel_grb;
            pv_idx[pv_cnt[5:0]] <= pixel_index;
            pv_cnt <= pv_cnt + 1;
        end
        if (frame_done) begin
            fd_pixels <= frame_pixels;
            fd_ovf    <= frame_overflow;
            fd_be     <= bit_error;
            fd_cnt    <= fd_cnt + 1;
        end
        if (bit_error) begin
            be_cnt <= be_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input logic v, input int n);
        neo_data = v;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        line(1'b1, b ? 35 : 18);
        line(1'b0, b ? 23 : 40);
    endtask

    task automatic send_word(input logic [23:0] wd);
        for (int i = 23; i >= 0; i--) send_bit(wd[i]);
    endtask

    task automatic snap();
        pv0 = pv_cnt;
        fd0 = fd_cnt;
        be0 = be_cnt;
    endtask

    initial begin
        reset    = 1'b1;
        neo_data = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_pv", 32'(pixel_valid), 0);
        check("rst_idx", 32'(pixel_index), 0);
        check("rst_grb", 32'(pixel_grb), 0);
        check("rst_fd", 32'(frame_done), 0);
        check("rst_fpix", 32'(frame_pixels), 0);
        check("rst_fovf", 32'(frame_overflow), 0);
        check("rst_be", 32'(bit_error), 0);
        reset = 1'b0;
        line(1'b0, 10);

        // Loopback-style frame of five pixels
        snap();
        send_word(24'hA53C0F);
        for (int i = 0; i < 4; i++) send_word(24'h000000);
        line(1'b0, 2600);
        check("lb_pv_cnt", 32'(pv_cnt - pv0), 5);
        check("lb_grb0", 32'(pv_grb[pv0[5:0]]), 32'hA53C0F);
        check("lb_idx0", 32'(pv_idx[pv0[5:0]]), 0);
        check("lb_grb4", 32'(pv_grb[6'(pv0 + 4)]), 0);
        check("lb_idx4", 32'(pv_idx[6'(pv0 + 4)]), 4);
        check("lb_fd_cnt", 32'(fd_cnt - fd0), 1);
        check("lb_fpix", 32'(fd_pixels), 5);
        check("lb_fovf", 32'(fd_ovf), 0);
        check("lb_be", 32'(be_cnt - be0), 0);
        check("lb_hold_idx", 32'(pixel_index), 4);
        check("lb_hold_fpix", 32'(frame_pixels), 5);

        // Width boundaries 26 / 27 / 50 give 0 / 1 / 1
        snap();
        line(1'b1, 26); line(1'b0, 30);
        line(1'b1, 27); line(1'b0, 30);
        line(1'b1, 50); line(1'b0, 30);
        for (int i = 0; i < 21; i++) send_bit(1'b0);
        line(1'b0, 2600);
        check("wb_pv_cnt", 32'(pv_cnt - pv0), 1);
        check("wb_grb", 32'(pv_grb[pv0[5:0]]), 32'h600000);
        check("wb_idx", 32'(pv_idx[pv0[5:0]]), 0);
        check("wb_fpix", 32'(fd_pixels), 1);
        check("wb_be", 32'(be_cnt - be0), 0);

        // Width 51 is a protocol error; frame is abandoned
        snap();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        line(1'b1, 51);
        line(1'b0, 3);
        check("err_be", 32'(be_cnt - be0), 1);
        line(1'b0, 2600);
        check("err_no_fd", 32'(fd_cnt - fd0), 0);
        check("err_be_once", 32'(be_cnt - be0), 1);
        check("err_pv", 32'(pv_cnt - pv0), 0);

        // Short glitches between bits are ignored
        snap();
        w = 24'hC3A581;
        for (int i = 23; i >= 0; i--) begin
            send_bit(w[i]);
            line(1'b1, 5);
            line(1'b0, 10);
        end
        line(1'b0, 2600);
        check("gl_pv_cnt", 32'(pv_cnt - pv0), 1);
        check("gl_grb", 32'(pv_grb[pv0[5:0]]), 32'hC3A581);
        check("gl_be", 32'(be_cnt - be0), 0);
        check("gl_fpix", 32'(fd_pixels), 1);

        // Partial word at latch
        snap();
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        line(1'b0, 2600);
        check("pw_fd_cnt", 32'(fd_cnt - fd0), 1);
        check("pw_fpix", 32'(fd_pixels), 0);
        check("pw_be_same", 32'(fd_be), 1);
        check("pw_pv", 32'(pv_cnt - pv0), 0);
        check("pw_be_cnt", 32'(be_cnt - be0), 1);

        // Overflow: seven words into a five-pixel frame
        snap();
        for (int i = 1; i <= 7; i++) send_word(24'(i) * 24'h111111);
        line(1'b0, 2600);
        check("ov_pv_cnt", 32'(pv_cnt - pv0), 5);
        check("ov_idx4", 32'(pv_idx[6'(pv0 + 4)]), 4);
        check("ov_grb4", 32'(pv_grb[6'(pv0 + 4)]), 32'h555555);
        check("ov_fpix", 32'(fd_pixels), 5);
        check("ov_fovf", 32'(fd_ovf), 1);
        snap();
        send_word(24'h0F0F0F);
        line(1'b0, 2600);
        check("ov2_fovf", 32'(fd_ovf), 0);
        check("ov2_fpix", 32'(fd_pixels), 1);
        check("ov2_idx", 32'(pv_idx[pv0[5:0]]), 0);

        // 2499 low cycles keep the frame open
        snap();
        w = 24'h123457;
        for (int i = 23; i >= 1; i--) send_bit(w[i]);
        line(1'b1, 35);
        line(1'b0, 2499);
        send_word(24'h654321);
        check("lt_fd_open", 32'(fd_cnt - fd0), 0);
        check("lt_pv_cnt", 32'(pv_cnt - pv0), 2);
        check("lt_idx1", 32'(pv_idx[6'(pv0 + 1)]), 1);
        check("lt_grb1", 32'(pv_grb[6'(pv0 + 1)]), 32'h654321);
        line(1'b0, 2600);
        check("lt_fpix", 32'(fd_pixels), 2);

        // Exactly 2500 low cycles then a rise: latch, then a new frame
        snap();
        w = 24'hABCDEF;
        for (int i = 23; i >= 1; i--) send_bit(w[i]);
        line(1'b1, 35);
        line(1'b0, 2500);
        send_word(24'h13579B);
        check("lx_fd_cnt", 32'(fd_cnt - fd0), 1);
        check("lx_idx", 32'(pv_idx[6'(pv0 + 1)]), 0);
        check("lx_grb", 32'(pv_grb[6'(pv0 + 1)]), 32'h13579B);
        line(1'b0, 2600);
        check("lx_fd2", 32'(fd_cnt - fd0), 2);
        check("lx_fpix", 32'(fd_pixels), 1);

        // Reset mid-word
        snap();
        for (int i = 0; i < 12; i++) send_bit(1'b1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mr_grb", 32'(pixel_grb), 0);
        check("mr_idx", 32'(pixel_index), 0);
        check("mr_fpix", 32'(frame_pixels), 0);
        check("mr_pv", 32'(pixel_valid), 0);
        reset = 1'b0;
        line(1'b0, 2600);
        check("mr_no_fd", 32'(fd_cnt - fd0), 0);
        check("mr_no_be", 32'(be_cnt - be0), 0);
        send_word(24'h0000FF);
        line(1'b0, 2600);
        check("mr_idx0", 32'(pv_idx[pv0[5:0]]), 0);
        check("mr_grb0", 32'(pv_grb[pv0[5:0]]), 32'h0000FF);
        check("mr_fpix1", 32'(fd_pixels), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
